// File: rtl/data_port_master_if.sv
// Core-side load/store bundle plus the word-indexed memory data port.
// The master modport is the sequencer; the slave modport is the execute stage and memory.
interface data_port_master_if;
    logic        req;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] d_addr;
    logic        mem_we;
    logic [31:0] mem_di;
    logic [31:0] mem_do;

    modport master (
        input  req, is_store, funct3, addr, wdata, mem_do,
        output ready, done, err, rdata, d_addr, mem_we, mem_di
    );

    modport slave (
        output req, is_store, funct3, addr, wdata, mem_do,
        input  ready, done, err, rdata, d_addr, mem_we, mem_di
    );
endinterface

// File: rtl/data_port_master.sv
// Byte-addressed RV32I load/store sequencer over a full-word memory port.
// Sub-word stores are done as read-modify-write through the mem_di register.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for req; request is latched and checked on accept
// S_LOAD   | word read, extracted/extended into rdata at the edge
// S_RMW_RD | word read, addressed byte/halfword merged into mem_di
// S_WRITE  | mem_we high, memory commits mem_di at the edge
// S_DONE   | one-cycle done pulse, err valid
module data_port_master #(
    parameter int DEPTH = 512
) (
    input  logic              clk,
    input  logic              rst,
    data_port_master_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic [2:0]  state;
    logic [1:0]  lane_q;
    logic [2:0]  f3_q;
    logic [15:0] wsub_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] d_addr_q;
    logic [31:0] mem_di_q;

    logic        f3_legal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    always_comb begin
        if (bus.is_store)
            f3_legal = bus.funct3 inside {3'b000, 3'b001, 3'b010};
        else
            f3_legal = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misaligned   = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                       ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
        out_of_range = ({2'b00, bus.addr[31:2]} >= DEPTH_W);
        req_err      = !f3_legal || misaligned || out_of_range;
    end

    always_comb begin
        ld_byte  = bus.mem_do[{lane_q, 3'b000} +: 8];
        ld_half  = lane_q[1] ? bus.mem_do[31:16] : bus.mem_do[15:0];
        load_val = bus.mem_do;
        case (f3_q)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'h0, ld_byte};
            3'b101:  load_val = {16'h0, ld_half};
            default: load_val = bus.mem_do;
        endcase
    end

    // Only SB (000) and SH (001) reach RMW_RD, so f3_q[0] selects the width.
    always_comb begin
        merged = bus.mem_do;
        if (f3_q[0])
            merged[{lane_q[1], 4'b0000} +: 16] = wsub_q;
        else
            merged[{lane_q, 3'b000} +: 8] = wsub_q[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            lane_q   <= 2'b00;
            f3_q     <= 3'b000;
            wsub_q   <= 16'h0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            d_addr_q <= 32'h0;
            mem_di_q <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        lane_q   <= bus.addr[1:0];
                        f3_q     <= bus.funct3;
                        wsub_q   <= bus.wdata[15:0];
                        d_addr_q <= {2'b00, bus.addr[31:2]};
                        err_q    <= req_err;
                        if (req_err) begin
                            state <= S_DONE;
                        end else if (!bus.is_store) begin
                            state <= S_LOAD;
                        end else if (bus.funct3[1]) begin
                            mem_di_q <= bus.wdata;
                            state    <= S_WRITE;
                        end else begin
                            state <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    rdata_q <= load_val;
                    state   <= S_DONE;
                end
                S_RMW_RD: begin
                    mem_di_q <= merged;
                    state    <= S_WRITE;
                end
                S_WRITE: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reset masks the strobes combinationally so an aborted transfer neither writes nor completes.
    assign bus.ready  = (state == S_IDLE) && !rst;
    assign bus.done   = (state == S_DONE) && !rst;
    assign bus.err    = err_q && (state == S_DONE) && !rst;
    assign bus.mem_we = (state == S_WRITE) && !rst;
    assign bus.rdata  = rdata_q;
    assign bus.d_addr = d_addr_q;
    assign bus.mem_di = mem_di_q;

endmodule

// File: doc/data_port_master.md
# data_port_master

Load/store sequencer on the core side of the unified word memory's data port. Takes byte-addressed RV32I load/store requests from the execute stage and drives the memory's word-indexed data port (`d_addr`, `we`, `di`, `do`). It performs byte/halfword extraction with sign or zero extension. Sub-word stores become a read-modify-write because the memory has only a full-word write port.

## Interface

- `DEPTH`, default 512: memory depth in 32-bit words; word index must be < DEPTH.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 1: request strobe, sampled only when `ready`=1.
- `is_store` input 1: 1 = store, 0 = load.
- `funct3` input 3: RV32I width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Other codes are illegal.
- `addr` input 32: byte address.
- `wdata` input 32: store data; byte/halfword taken from LSBs.
- `ready` output 1: FSM in IDLE and `rst`=0.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: valid with `done`. Set for misalignment, out-of-range address, or illegal `funct3`.
- `rdata` output 32: load result, valid from `done` until the next accepted load.
- `d_addr` output 32: word index to memory, equal to `addr[31:2]` zero-extended.
- `mem_we` output 1: memory write enable.
- `mem_di` output 32: memory write data.
- `mem_do` input 32: memory read data, combinational from `d_addr`.

## Operation

- FSM states: IDLE, LOAD, RMW_RD, WRITE, DONE.
- IDLE, on `req`=1:
  - Latch `addr`, `funct3`, `is_store`, `wdata`.
  - Compute the error condition:
    - H with `addr[0]`≠0.
    - W with `addr[1:0]`≠0.
    - `addr[31:2]` ≥ DEPTH.
    - Illegal `funct3`.
  - Next state:
    - Error: go to DONE with `err`=1; no memory access and no write.
    - Load: go to LOAD.
    - SW: go to WRITE with `mem_di` = `wdata`.
    - SB/SH: go to RMW_RD.
- LOAD: `d_addr` = latched word index. At the clock edge, register `rdata` from `mem_do`:
  - Byte lane = `addr[1:0]`, little-endian (lane 0 = bits 7:0).
  - Halfword lane = `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word unchanged.
  - Next state: DONE.
- RMW_RD: at the clock edge, capture `mem_do` into the merge register and replace only the addressed byte or halfword with `wdata[7:0]` or `wdata[15:0]`. Next state: WRITE.
- WRITE: `mem_we` = 1 and `mem_di` = merged or full word. Memory commits the write at the clock edge ending this cycle. Next state: DONE.
- DONE: `done`=1 for this cycle only. `err` as computed. Next state: IDLE.
- `mem_we` = (state==WRITE) & ~`rst`. It is never high in any other state.
- `d_addr` and `mem_di` hold stable from acceptance until return to IDLE.
- Stores never modify `rdata`. Errored loads leave `rdata` unchanged.

## Timing

- Reset (edge with `rst`=1):
  - State becomes IDLE.
  - `done`, `err`, `mem_we` = 0.
  - `rdata`, `d_addr`, `mem_di` = 0.
  - `ready`=0 while `rst` is high; `ready`=1 on the first cycle after.
- Reset mid-operation: the transaction is aborted and no `done` pulse is generated. Reset asserted during WRITE masks `mem_we` in that same cycle.
- Latency from the accept edge to the `done` cycle:
  - Error: 1 cycle.
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
- Throughput: `ready` returns in the cycle after `done`. The minimum request spacing is therefore latency+1 cycles.
- `req` while `ready`=0 is ignored. It is not queued.
- A load following a store to the same word returns the stored data, because the write commits before DONE.

## Test plan

- **LW.** Preload mem[5]=0x80F0_1234, then LW addr=0x14. Require `done` 2 cycles after accept, `rdata`=0x80F0_1234, `err`=0, and `mem_we` never high.
- **LB vs LBU.** With the same word, LB addr=0x17 gives `rdata`=0xFFFF_FF80; LBU addr=0x17 gives 0x0000_0080. LH addr=0x16 gives 0xFFFF_80F0.
- **SB read-modify-write.** SB addr=0x15 with `wdata`=0xAB. Require exactly one `mem_we` pulse, in the cycle 2 after accept, with `d_addr`=5 and `mem_di`=0x80F0_AB34. A following LW addr=0x14 reads 0x80F0_AB34.
- **Misalignment.** SH addr=0x13 and LW addr=0x16 each give `done` 1 cycle after accept with `err`=1, no `mem_we`, and `rdata` unchanged.
- **Out-of-range.** LW addr=0x800 (word 512) with DEPTH=512 gives `err`=1.
- **Reset mid-operation.** Assert `rst` during WRITE of an SH. Require `mem_we`=0 in that cycle, no `done` pulse, `ready`=1 one cycle after `rst` deasserts, and `d_addr`=0.
